// File: rtl/cmd_source_bank.sv
// cmd_source_bank: a bank of command entries written by address field. A sweep
// walks the entries in ascending order and issues every pending, not yet
// completed entry to the ALU over a valid/ready handshake, then reports how
// many entries went out.
module cmd_source_bank #(
   parameter int DW = 8,
   parameter int CW = 3,
   parameter int AW = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      w,
   input  logic [2+AW+CW+2*DW-1:0]   wdata,
   input  logic                      r,
   input  logic [AW-1:0]             raddr,
   output logic [2+AW+CW+2*DW-1:0]   rdata,
   input  logic                      aluop_st,
   output logic                      busy,
   output logic                      iss_valid,
   input  logic                      iss_ready,
   output logic [AW-1:0]             iss_addr,
   output logic [CW-1:0]             iss_cmd,
   output logic [DW-1:0]             iss_a,
   output logic [DW-1:0]             iss_b,
   output logic                      cap_en,
   output logic [AW:0]               iss_cnt
);

   localparam int DEPTH    = 2**AW;
   localparam int EW       = 2+AW+CW+2*DW;
   localparam int R_BIT    = EW-1;
   localparam int C_BIT    = EW-2;
   localparam int ADDR_LSB = CW+2*DW;
   localparam int CMD_LSB  = 2*DW;
   localparam int A_LSB    = DW;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      ISSUE,
      DONE
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [AW-1:0]   ptr;
   logic [AW-1:0]   ptr_next;
   logic [AW:0]     cnt;
   logic [AW:0]     cnt_next;

   logic [EW-1:0]   mem [DEPTH];

   logic [EW-1:0]   cur;
   logic [AW-1:0]   w_addr;
   logic            cur_pending;
   logic            ptr_last;
   logic            handshake;

   logic            busy_d;
   logic            valid_d;
   logic            cap_d;
   logic            latch_issue;
   logic            set_done;
   logic            load_cnt;

   // Entry currently under the scan pointer (pre-edge contents) and the
   // address field of an incoming write.
   assign cur         = mem[ptr];
   assign w_addr      = wdata[ADDR_LSB +: AW];
   assign cur_pending = cur[R_BIT] & ~cur[C_BIT];
   assign ptr_last    = (ptr == AW'(DEPTH-1));
   assign handshake   = iss_valid & iss_ready;

   // Sweep state, scan pointer and running issue counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= next_state;
         ptr   <= ptr_next;
         cnt   <= cnt_next;
      end
   end

   // Sweep sequencing: one entry examined per SCAN cycle, parking in ISSUE
   // until the ALU takes the command.
   always_comb begin
      next_state = state;
      ptr_next   = ptr;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (aluop_st) begin
               next_state = SCAN;
               ptr_next   = '0;
               cnt_next   = '0;
            end
         end
         SCAN: begin
            if (cur_pending) begin
               next_state = ISSUE;
            end else if (ptr_last) begin
               next_state = DONE;
            end else begin
               ptr_next = ptr + 1'b1;
            end
         end
         ISSUE: begin
            if (handshake) begin
               cnt_next = cnt + 1'b1;
               if (ptr_last) begin
                  next_state = DONE;
               end else begin
                  next_state = SCAN;
                  ptr_next   = ptr + 1'b1;
               end
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Decode the next state into the values the output registers load, so
   // every status output comes straight from a flop.
   always_comb begin
      busy_d      = (next_state != IDLE);
      valid_d     = (next_state == ISSUE);
      cap_d       = (next_state == DONE);
      load_cnt    = (next_state == DONE);
      latch_issue = (state == SCAN) && cur_pending;
      set_done    = handshake && !(w && (w_addr == ptr));
   end

   // Registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         iss_valid <= 1'b0;
         cap_en    <= 1'b0;
      end else begin
         busy      <= busy_d;
         iss_valid <= valid_d;
         cap_en    <= cap_d;
      end
   end

   // Issue fields are captured once when a pending entry is found and held
   // until the handshake, so later writes to that entry cannot disturb them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_addr <= '0;
         iss_cmd  <= '0;
         iss_a    <= '0;
         iss_b    <= '0;
      end else if (latch_issue) begin
         iss_addr <= ptr;
         iss_cmd  <= cur[CMD_LSB +: CW];
         iss_a    <= cur[A_LSB +: DW];
         iss_b    <= cur[0 +: DW];
      end
   end

   // Issue count is published together with the sweep-done pulse; it
   // includes a handshake that lands on the edge entering DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_cnt <= '0;
      end else if (load_cnt) begin
         iss_cnt <= cnt_next;
      end
   end

   // Entry storage: host writes always clear C; a handshake marks the issued
   // entry complete unless a host write to the same entry lands on that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (set_done) begin
            mem[ptr][C_BIT] <= 1'b1;
         end
         if (w) begin
            mem[w_addr] <= {wdata[R_BIT], 1'b0, wdata[EW-3:0]};
         end
      end
   end

   // Registered read port returning the contents before this edge's updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (r) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: tb/tb_cmd_source_bank.sv
// tb_cmd_source_bank: table-driven read/write vectors, directed sweep
// sequences and a randomized sweep run against an entry-level model.
module tb_cmd_source_bank;

   localparam int DW    = 8;
   localparam int CW    = 3;
   localparam int AW    = 3;
   localparam int DEPTH = 2**AW;
   localparam int EW    = 2+AW+CW+2*DW;
   localparam int RW    = AW+CW+2*DW;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            w         = 1'b0;
   logic [EW-1:0]   wdata     = '0;
   logic            r         = 1'b0;
   logic [AW-1:0]   raddr     = '0;
   logic            aluop_st  = 1'b0;
   logic            iss_ready = 1'b0;
   logic [EW-1:0]   rdata;
   logic            busy;
   logic            iss_valid;
   logic [AW-1:0]   iss_addr;
   logic [CW-1:0]   iss_cmd;
   logic [DW-1:0]   iss_a;
   logic [DW-1:0]   iss_b;
   logic            cap_en;
   logic [AW:0]     iss_cnt;

   int errors       = 0;
   int checks       = 0;
   int cyc          = 0;
   int valid_cycles = 0;
   int cap_count    = 0;
   logic [RW-1:0] hs_q [$];

   typedef struct {
      logic          do_w;
      logic [EW-1:0] wdata;
      logic          do_r;
      logic [AW-1:0] raddr;
      logic [EW-1:0] exp_rdata;
      string         name;
   } vec_t;

   vec_t vecs [$];

   // Entry-level reference model
   logic          m_r    [DEPTH];
   logic          m_c    [DEPTH];
   logic [AW-1:0] m_addr [DEPTH];
   logic [CW-1:0] m_cmd  [DEPTH];
   logic [DW-1:0] m_a    [DEPTH];
   logic [DW-1:0] m_b    [DEPTH];

   cmd_source_bank #(.DW(DW), .CW(CW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .w         (w),
      .wdata     (wdata),
      .r         (r),
      .raddr     (raddr),
      .rdata     (rdata),
      .aluop_st  (aluop_st),
      .busy      (busy),
      .iss_valid (iss_valid),
      .iss_ready (iss_ready),
      .iss_addr  (iss_addr),
      .iss_cmd   (iss_cmd),
      .iss_a     (iss_a),
      .iss_b     (iss_b),
      .cap_en    (cap_en),
      .iss_cnt   (iss_cnt)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Observe handshakes, issue cycles and done pulses mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (iss_valid) valid_cycles++;
         if (iss_valid && iss_ready) hs_q.push_back({iss_addr, iss_cmd, iss_a, iss_b});
         if (cap_en) cap_count++;
      end
   end

   // Hard stop in case the sequence hangs
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [EW-1:0] mk(input logic rr, input logic cc, input logic [AW-1:0] ad,
                                        input logic [CW-1:0] cm, input logic [DW-1:0] aa,
                                        input logic [DW-1:0] bb);
      return {rr, cc, ad, cm, aa, bb};
   endfunction

   function automatic logic [RW-1:0] rec(input logic [AW-1:0] ad, input logic [CW-1:0] cm,
                                         input logic [DW-1:0] aa, input logic [DW-1:0] bb);
      return {ad, cm, aa, bb};
   endfunction

   function automatic logic [RW-1:0] hs_at(input int i);
      if (i < hs_q.size()) return hs_q[i];
      return '1;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply_reset();
      rst_n     = 1'b0;
      w         = 1'b0;
      r         = 1'b0;
      aluop_st  = 1'b0;
      iss_ready = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         m_r[i] = 1'b0; m_c[i] = 1'b0; m_addr[i] = '0;
         m_cmd[i] = '0; m_a[i] = '0; m_b[i] = '0;
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      w     = v.do_w;
      wdata = v.wdata;
      r     = v.do_r;
      raddr = v.raddr;
      tick();
      w = 1'b0;
      r = 1'b0;
      check_output(v.name, 32'(rdata), 32'(v.exp_rdata));
   endtask

   task automatic write_entry(input logic [EW-1:0] d);
      w     = 1'b1;
      wdata = d;
      tick();
      w = 1'b0;
   endtask

   task automatic read_entry(input logic [AW-1:0] a, input logic [EW-1:0] exp, input string name);
      r     = 1'b1;
      raddr = a;
      tick();
      r = 1'b0;
      check_output(name, 32'(rdata), 32'(exp));
   endtask

   task automatic start_sweep(output int t0);
      hs_q.delete();
      valid_cycles = 0;
      aluop_st     = 1'b1;
      tick();
      aluop_st = 1'b0;
      t0       = cyc - 1;
   endtask

   task automatic wait_cap(input int t0, input bit rand_ready, output int n);
      int budget;
      budget = 300;
      while (!cap_en && budget > 0) begin
         if (rand_ready) iss_ready = 1'($urandom_range(0, 1));
         tick();
         budget--;
      end
      if (!cap_en) begin
         checks++;
         errors++;
         $display("[TB] FAIL cap_timeout: got cap_en=%0b expected 1 within budget", cap_en);
      end
      n = cyc - t0;
   endtask

   task automatic wait_valid(input string name);
      int budget;
      budget = 50;
      while (!iss_valid && budget > 0) begin
         tick();
         budget--;
      end
      if (!iss_valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: got iss_valid=0 expected 1 within budget", name);
      end
   endtask

   initial begin
      int t0;
      int n;
      int caps_before;
      logic [RW-1:0] exp_q [$];

      // Reset state
      apply_reset();
      check_output("rst_busy",      32'(busy),      0);
      check_output("rst_iss_valid", 32'(iss_valid), 0);
      check_output("rst_cap_en",    32'(cap_en),    0);
      check_output("rst_iss_cnt",   32'(iss_cnt),   0);
      check_output("rst_rdata",     32'(rdata),     0);
      check_output("rst_iss_addr",  32'(iss_addr),  0);

      // Read/write vector table
      for (int a = 0; a < DEPTH; a++)
         vecs.push_back('{1'b0, '0, 1'b1, AW'(a), '0, "rst_read"});
      vecs.push_back('{1'b1, mk(1, 0, 5, 3, 8'hAA, 8'h55), 1'b1, 3'd5, '0, "rd_same_edge_old"});
      vecs.push_back('{1'b0, '0, 1'b1, 3'd5, mk(1, 0, 5, 3, 8'hAA, 8'h55), "rd_after_wr"});
      vecs.push_back('{1'b1, mk(0, 1, 6, 2, 8'h11, 8'h22), 1'b1, 3'd6, '0, "wr6_old"});
      vecs.push_back('{1'b0, '0, 1'b1, 3'd6, mk(0, 0, 6, 2, 8'h11, 8'h22), "c_forced_zero"});
      vecs.push_back('{1'b0, '0, 1'b0, 3'd0, mk(0, 0, 6, 2, 8'h11, 8'h22), "rdata_hold"});
      vecs.push_back('{1'b1, mk(1, 0, 5, 7, 8'h01, 8'h02), 1'b0, 3'd0, mk(0, 0, 6, 2, 8'h11, 8'h22), "hold_on_write"});
      vecs.push_back('{1'b0, '0, 1'b1, 3'd5, mk(1, 0, 5, 7, 8'h01, 8'h02), "overwrite"});
      foreach (vecs[i]) apply_stimulus(vecs[i]);

      // Empty sweep
      apply_reset();
      start_sweep(t0);
      wait_cap(t0, 1'b0, n);
      check_output("empty_cap_cycle", 32'(n), DEPTH+1);
      check_output("empty_iss_cnt",   32'(iss_cnt), 0);
      check_output("empty_issues",    32'(hs_q.size() + valid_cycles), 0);
      tick();
      check_output("empty_cap_one_cycle", 32'(cap_en), 0);
      check_output("empty_busy_low",      32'(busy),   0);

      // Two issues, ready held high
      write_entry(mk(1, 0, 2, 1, 8'h12, 8'h34));
      write_entry(mk(1, 0, 7, 5, 8'hFF, 8'h01));
      iss_ready = 1'b1;
      start_sweep(t0);
      wait_cap(t0, 1'b0, n);
      check_output("two_cap_cycle", 32'(n), DEPTH+3);
      check_output("two_iss_cnt",   32'(iss_cnt), 2);
      check_output("two_hs_count",  32'(hs_q.size()), 2);
      check_output("two_first",     32'(hs_at(0)), 32'(rec(2, 1, 8'h12, 8'h34)));
      check_output("two_second",    32'(hs_at(1)), 32'(rec(7, 5, 8'hFF, 8'h01)));
      tick();
      read_entry(3'd2, mk(1, 1, 2, 1, 8'h12, 8'h34), "two_c_set");

      // Completed entries are not reissued; a rewrite makes one pending again
      start_sweep(t0);
      wait_cap(t0, 1'b0, n);
      check_output("again_cap_cycle", 32'(n), DEPTH+1);
      check_output("again_iss_cnt",   32'(iss_cnt), 0);
      tick();
      write_entry(mk(1, 0, 2, 1, 8'h12, 8'h34));
      start_sweep(t0);
      wait_cap(t0, 1'b0, n);
      check_output("reissue_cap_cycle", 32'(n), DEPTH+2);
      check_output("reissue_iss_cnt",   32'(iss_cnt), 1);
      check_output("reissue_entry",     32'(hs_at(0)), 32'(rec(2, 1, 8'h12, 8'h34)));
      tick();

      // Stalled issue: fields hold, mid-wait write and start pulses ignored
      write_entry(mk(1, 0, 3, 6, 8'h33, 8'h44));
      iss_ready = 1'b0;
      start_sweep(t0);
      wait_valid("stall_valid_timeout");
      check_output("stall_first_valid", 32'(cyc - t0), 5);
      for (int i = 0; i < 5; i++) begin
         check_output("stall_valid", 32'(iss_valid), 1);
         check_output("stall_addr",  32'(iss_addr),  3);
         check_output("stall_cmd",   32'(iss_cmd),   6);
         check_output("stall_ab",    32'({iss_a, iss_b}), 32'h3344);
         if (i == 1) begin
            w     = 1'b1;
            wdata = mk(1, 0, 3, 2, 8'h99, 8'h66);
         end
         if (i == 2) aluop_st = 1'b1;
         tick();
         w        = 1'b0;
         aluop_st = 1'b0;
      end
      iss_ready = 1'b1;
      wait_cap(t0, 1'b0, n);
      check_output("stall_cap_cycle", 32'(n), DEPTH+7);
      check_output("stall_iss_cnt",   32'(iss_cnt), 1);
      check_output("stall_entry",     32'(hs_at(0)), 32'(rec(3, 6, 8'h33, 8'h44)));
      tick();
      tick();
      check_output("stall_no_restart", 32'(busy), 0);
      read_entry(3'd3, mk(1, 1, 3, 2, 8'h99, 8'h66), "stall_rewritten_entry");

      // Reset in the middle of an issue
      write_entry(mk(1, 0, 1, 4, 8'h5A, 8'hA5));
      iss_ready = 1'b0;
      start_sweep(t0);
      wait_valid("abort_valid_timeout");
      caps_before = cap_count;
      rst_n = 1'b0;
      #1;
      check_output("abort_iss_valid", 32'(iss_valid), 0);
      check_output("abort_busy",      32'(busy),      0);
      check_output("abort_cap_en",    32'(cap_en),    0);
      tick();
      rst_n = 1'b1;
      tick();
      for (int a = 0; a < DEPTH; a++) read_entry(AW'(a), '0, "abort_entry_cleared");
      check_output("abort_no_cap", 32'(cap_count), 32'(caps_before));

      // Write on the handshake edge wins over completion
      apply_reset();
      write_entry(mk(1, 0, 4, 2, 8'h10, 8'h20));
      start_sweep(t0);
      wait_valid("collide_valid_timeout");
      iss_ready = 1'b1;
      w         = 1'b1;
      wdata     = mk(1, 0, 4, 2, 8'h77, 8'h88);
      tick();
      w = 1'b0;
      wait_cap(t0, 1'b0, n);
      check_output("collide_cap_cycle", 32'(n), DEPTH+2);
      check_output("collide_iss_cnt",   32'(iss_cnt), 1);
      check_output("collide_entry",     32'(hs_at(0)), 32'(rec(4, 2, 8'h10, 8'h20)));
      tick();
      read_entry(3'd4, mk(1, 0, 4, 2, 8'h77, 8'h88), "collide_write_wins");

      // Randomized sweeps against the entry model
      apply_reset();
      for (int it = 0; it < 25; it++) begin
         int nw;
         logic [AW-1:0] ra;
         nw = $urandom_range(0, 4);
         for (int k = 0; k < nw; k++) begin
            logic [AW-1:0] ad;
            logic          rr;
            logic [CW-1:0] cm;
            logic [DW-1:0] aa;
            logic [DW-1:0] bb;
            ad = AW'($urandom_range(0, DEPTH-1));
            rr = 1'($urandom_range(0, 1));
            cm = CW'($urandom);
            aa = DW'($urandom);
            bb = DW'($urandom);
            write_entry(mk(rr, 1'($urandom_range(0, 1)), ad, cm, aa, bb));
            m_r[ad] = rr; m_c[ad] = 1'b0; m_addr[ad] = ad;
            m_cmd[ad] = cm; m_a[ad] = aa; m_b[ad] = bb;
         end
         ra = AW'($urandom_range(0, DEPTH-1));
         read_entry(ra, mk(m_r[ra], m_c[ra], m_addr[ra], m_cmd[ra], m_a[ra], m_b[ra]), "rand_read");

         exp_q.delete();
         for (int i = 0; i < DEPTH; i++)
            if (m_r[i] && !m_c[i]) exp_q.push_back(rec(AW'(i), m_cmd[i], m_a[i], m_b[i]));

         start_sweep(t0);
         wait_cap(t0, 1'b1, n);
         check_output("rand_iss_cnt",   32'(iss_cnt), 32'(exp_q.size()));
         check_output("rand_hs_count",  32'(hs_q.size()), 32'(exp_q.size()));
         check_output("rand_cap_cycle", 32'(n), 32'(DEPTH + 1 + valid_cycles));
         foreach (exp_q[i]) check_output("rand_issue", 32'(hs_at(i)), 32'(exp_q[i]));
         for (int i = 0; i < DEPTH; i++)
            if (m_r[i]) m_c[i] = 1'b1;
         iss_ready = 1'b0;
         tick();
         check_output("rand_idle", 32'(busy), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cmd_source_bank.md
# cmd_source_bank

Parametrised command source bank for the ALU datapath: holds 2**AW command entries written by address field, scans them in ascending order on an `aluop_st` pulse, and issues every pending, not-yet-completed entry to the ALU over a valid/ready handshake. It reports sweep completion with `cap_en` and an issued-entry count. It sits between the host write path and the ALU operand/command inputs.

## Interface
- `DW`, 8: operand width (a, b)
- `CW`, 3: command field width
- `AW`, 3: entry address width; DEPTH = 2**AW
- Derived EW = 2+AW+CW+2*DW (24 at defaults). Entry format, MSB first: R (pending), C (completed), addr[AW], cmd[CW], a[DW], b[DW]

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `w`  in  1  write strobe
- `wdata`  in  EW  entry word; target entry = wdata addr field
- `r`  in  1  read strobe
- `raddr`  in  AW  read address
- `rdata`  out  EW  read data, registered
- `aluop_st`  in  1  start-sweep pulse
- `busy`  out  1  sweep in progress
- `iss_valid`  out  1  issue request to ALU
- `iss_ready`  in  1  ALU accepts issue
- `iss_addr`  out  AW  issued entry address
- `iss_cmd`  out  CW  issued command
- `iss_a`, `iss_b`  out  DW  issued operands
- `cap_en`  out  1  one-cycle sweep-done pulse
- `iss_cnt`  out  AW+1  entries issued in last sweep

## Operation
- Write: `w`=1 → entry[wdata.addr] <= wdata with C forced to 0; R taken from wdata. One write per cycle, accepted in any state.
- Read: `r`=1 → `rdata` <= entry[raddr] (pre-edge contents) next cycle; holds otherwise.
- FSM states IDLE, SCAN, ISSUE, DONE; pointer `ptr` (AW bits).
  - IDLE: `busy`=0. `aluop_st`=1 → SCAN, ptr=0, issue counter=0.
  - SCAN: examine entry[ptr]. If R=1 and C=0 → ISSUE, latch addr/cmd/a/b into issue registers. Else if ptr=DEPTH-1 → DONE; else ptr+1, stay SCAN.
  - ISSUE: `iss_valid`=1, issue fields held stable until `iss_valid`&&`iss_ready`. On handshake: entry[ptr].C <= 1, counter+1, then ptr=DEPTH-1 → DONE, else ptr+1 → SCAN.
  - DONE: `cap_en`=1 for exactly one cycle, `iss_cnt` <= counter; → IDLE.
- `busy`=1 in SCAN, ISSUE and DONE.
- `aluop_st` is ignored while busy.
- Write/scan collisions:
  - A write to entry[ptr] in the same cycle as SCAN examines it: SCAN uses the old contents.
  - A write to entry[ptr] during ISSUE leaves the latched issue fields unchanged. If it lands on the handshake cycle, the write wins: C=0.
- Counter width AW+1; cannot overflow (maximum DEPTH).

## Timing
- Reset (async, `rst_n`=0): all entries 0, state IDLE, ptr 0, `rdata` 0, `busy` 0, `iss_valid` 0, issue fields 0, `cap_en` 0, `iss_cnt` 0. Reset mid-sweep aborts it immediately; no `cap_en`.
- All outputs are registered.
- `aluop_st` sampled at edge t → SCAN of entry 0 in cycle t+1.
- SCAN visits one entry per cycle. A pending entry found in SCAN cycle k gives `iss_valid` in cycle k+1.
- Handshake in cycle m → next entry scanned in cycle m+1.
- Empty sweep: `cap_en` high in cycle t+DEPTH+1; `busy` low from t+DEPTH+2.
- Sweep with N issues, each accepted on first `iss_valid` cycle: `cap_en` at t+DEPTH+N+1.
- `iss_ready` may be held high continuously; `iss_valid` never depends combinationally on `iss_ready`.

## Test plan
- Reset, then `r` on every address → `rdata`=0 for all; `aluop_st` → `cap_en` exactly 9 cycles later (DEPTH=8), `iss_cnt`=0, no `iss_valid`.
- Write R=1 entries at addr 2 (cmd 1, a=0x12, b=0x34) and addr 7 (cmd 5, a=0xFF, b=0x01), `iss_ready`=1 → two issues in order 2 then 7 with those fields; `cap_en` at t+11; `iss_cnt`=2; read addr 2 shows C=1.
- Second `aluop_st` with no new writes → no issues (C=1), `iss_cnt`=0. Rewrite addr 2 → C cleared, next sweep reissues it.
- Hold `iss_ready`=0 for 5 cycles on addr 3 issue → `iss_valid` and fields stable for all 5 cycles; a write to addr 3 mid-wait does not change the issued fields; `aluop_st` pulses during the wait are ignored.
- Assert `rst_n`=0 during ISSUE → `iss_valid`, `busy`, `cap_en` go to 0 immediately; entries read back 0.
- Write addr 4 on the same edge as its handshake → read shows C=0 (write wins); `iss_cnt` still counts the issue.
